// File: rtl/neokeon_encrypt_ctrl_if.sv
// Bundle between the NOEKEON encryption sequencer, its requester and the
// external combinational full-round function.
interface neokeon_encrypt_ctrl_if;
   logic         start;
   logic [127:0] data_key;
   logic [127:0] data_state;
   logic [127:0] rf_key;
   logic [127:0] rf_state;
   logic [31:0]  rf_const1;
   logic [31:0]  rf_const2;
   logic [127:0] rf_next_state;
   logic         busy;
   logic         valid;
   logic [127:0] data_out;

   // requester + round-function side
   modport master (
      output start, data_key, data_state, rf_next_state,
      input  rf_key, rf_state, rf_const1, rf_const2, busy, valid, data_out
   );

   // sequencer side
   modport slave (
      input  start, data_key, data_state, rf_next_state,
      output rf_key, rf_state, rf_const1, rf_const2, busy, valid, data_out
   );
endinterface

// File: rtl/neokeon_encrypt_ctrl.sv
// Iterative NOEKEON-128 direct-key encryption sequencer. Feeds an external
// combinational round function one round per clock, then applies the output
// transform (final constant XOR followed by Theta) and pulses valid.
module neokeon_encrypt_ctrl #(
   parameter int         ROUNDS  = 16,
   parameter logic [7:0] RC_INIT = 8'h80
) (
   input  logic                  clk,
   input  logic                  rst,
   neokeon_encrypt_ctrl_if.slave bus
);
   localparam int            CW   = $clog2(ROUNDS + 1);
   localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

   fsm_t         fsm, fsm_nxt;
   logic [127:0] st, key, result;
   logic [7:0]   rc;
   logic [CW-1:0] cnt;
   logic         valid_q;
   logic         busy_d;

   // t ^ rotl8(t) ^ rotr8(t)
   function automatic logic [31:0] mix(input logic [31:0] t);
      return t ^ {t[23:0], t[31:24]} ^ {t[7:0], t[31:8]};
   endfunction

   function automatic logic [127:0] theta(input logic [127:0] k, input logic [127:0] a);
      logic [31:0] a0, a1, a2, a3, t;
      a0 = a[127:96]; a1 = a[95:64]; a2 = a[63:32]; a3 = a[31:0];
      t  = mix(a0 ^ a2);
      a1 = a1 ^ t;
      a3 = a3 ^ t;
      a0 = a0 ^ k[127:96];
      a1 = a1 ^ k[95:64];
      a2 = a2 ^ k[63:32];
      a3 = a3 ^ k[31:0];
      t  = mix(a1 ^ a3);
      a0 = a0 ^ t;
      a2 = a2 ^ t;
      return {a0, a1, a2, a3};
   endfunction

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm <= IDLE;
      else     fsm <= fsm_nxt;
   end

   // next-state logic: ROUNDS round cycles, then one output-transform cycle
   always_comb begin
      fsm_nxt = fsm;
      case (fsm)
         IDLE:    if (bus.start) fsm_nxt = ROUND;
         ROUND:   if (cnt == LAST) fsm_nxt = FINAL;
         FINAL:   fsm_nxt = IDLE;
         default: fsm_nxt = IDLE;
      endcase
   end

   // output decode straight from the state
   always_comb begin
      busy_d = 1'b0;
      case (fsm)
         ROUND, FINAL: busy_d = 1'b1;
         default:      busy_d = 1'b0;
      endcase
   end

   // datapath: latch inputs on start, take the round result, compute ciphertext
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st     <= '0;
         key    <= '0;
         rc     <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         case (fsm)
            IDLE: if (bus.start) begin
               st  <= bus.data_state;
               key <= bus.data_key;
               rc  <= RC_INIT;
               cnt <= '0;
            end
            ROUND: begin
               st  <= bus.rf_next_state;
               rc  <= {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
               cnt <= cnt + 1'b1;
            end
            FINAL:   result <= theta(key, st ^ {24'h0, rc, 96'h0});
            default: ;
         endcase
      end
   end

   // one-cycle completion pulse, aligned with the new result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= (fsm == FINAL);
   end

   assign bus.rf_key    = key;
   assign bus.rf_state  = st;
   assign bus.rf_const1 = {24'h0, rc};
   assign bus.rf_const2 = 32'h0;
   assign bus.busy      = busy_d;
   assign bus.valid     = valid_q;
   assign bus.data_out  = result;
endmodule

// File: tb/tb_neokeon_encrypt_ctrl.sv
// Bench for the NOEKEON encryption sequencer: supplies the combinational
// round function, keeps an algorithm-level model and checks outputs each cycle.
module tb_neokeon_encrypt_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   neokeon_encrypt_ctrl_if bus();

   neokeon_encrypt_ctrl #(.ROUNDS(16), .RC_INIT(8'h80)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] CT1  = 128'hb1656851699e29fa24b70148503d2dfc;
   localparam logic [127:0] CT2  = 128'h2a78421b87c7d0924f26113f1d1349b2;
   localparam logic [127:0] CT3  = 128'he2f687e07b75660ffc372233bc47532c;

   logic [7:0] rc_tab [17] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                               8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] nk_theta(input logic [127:0] k, input logic [127:0] s);
      logic [31:0] a[4];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) a[i] = s[127-32*i -: 32];
      t = a[0] ^ a[2];
      t = t ^ rotl(t, 8) ^ rotl(t, 24);
      a[1] ^= t; a[3] ^= t;
      for (int i = 0; i < 4; i++) a[i] ^= k[127-32*i -: 32];
      t = a[1] ^ a[3];
      t = t ^ rotl(t, 8) ^ rotl(t, 24);
      a[0] ^= t; a[2] ^= t;
      return {a[0], a[1], a[2], a[3]};
   endfunction

   // full NOEKEON round: const1, Theta, const2, Pi1, Gamma, Pi2
   function automatic logic [127:0] round_fn(input logic [127:0] k, input logic [127:0] s_in,
                                             input logic [31:0] c1, input logic [31:0] c2);
      logic [127:0] s;
      logic [31:0]  a0, a1, a2, a3, tmp;
      s = s_in;
      s[127:96] ^= c1;
      s = nk_theta(k, s);
      s[127:96] ^= c2;
      a0 = s[127:96]; a1 = s[95:64]; a2 = s[63:32]; a3 = s[31:0];
      a1 = rotl(a1, 1); a2 = rotl(a2, 5); a3 = rotl(a3, 2);
      a1 ^= ~a3 & ~a2;
      a0 ^= a2 & a1;
      tmp = a3; a3 = a0; a0 = tmp;
      a2 ^= a0 ^ a1 ^ a3;
      a1 ^= ~a3 & ~a2;
      a0 ^= a2 & a1;
      a1 = rotl(a1, 31); a2 = rotl(a2, 27); a3 = rotl(a3, 30);
      return {a0, a1, a2, a3};
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
      logic [127:0] s;
      s = p;
      for (int r = 0; r < 16; r++) s = round_fn(k, s, {24'h0, rc_tab[r]}, 32'h0);
      s[127:96] ^= {24'h0, rc_tab[16]};
      return nk_theta(k, s);
   endfunction

   // environment: the combinational round function the sequencer drives
   assign bus.rf_next_state = round_fn(bus.rf_key, bus.rf_state, bus.rf_const1, bus.rf_const2);

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // model: countdown of edges left until the result appears
   int           m_left;
   logic         m_valid;
   logic [127:0] m_out, m_pend, m_key, m_pt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left  <= 0;
         m_valid <= 1'b0;
         m_out   <= '0;
      end else begin
         m_valid <= 1'b0;
         if (m_left == 0) begin
            if (bus.start) begin
               m_left <= 17;
               m_pend <= encrypt(bus.data_key, bus.data_state);
               m_key  <= bus.data_key;
               m_pt   <= bus.data_state;
            end
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_valid <= 1'b1;
               m_out   <= m_pend;
            end
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", 128'(bus.busy), 128'(m_left != 0));
         chk("valid", 128'(bus.valid), 128'(m_valid));
         chk("data_out", bus.data_out, m_out);
         chk("rf_const2", 128'(bus.rf_const2), 128'h0);
         if (m_left != 0) begin
            chk("rf_const1", 128'(bus.rf_const1), {120'h0, rc_tab[17-m_left]});
            chk("rf_key", bus.rf_key, m_key);
            if (m_left == 17) chk("rf_state_first", bus.rf_state, m_pt);
         end
      end
   end

   task automatic start_run(input logic [127:0] k, input logic [127:0] p);
      @(negedge clk);
      bus.data_key   = k;
      bus.data_state = p;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.data_key   = {$urandom, $urandom, $urandom, $urandom};
      bus.data_state = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // waits (bounded) for valid; n counts negedges since start was driven
   task automatic wait_valid(input string name, input logic [127:0] exp, output int n);
      n = 1;
      while (!bus.valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_valid_seen"}, 128'(bus.valid), 128'h1);
      chk({name, "_result"}, bus.data_out, exp);
   endtask

   initial begin
      int lat;
      bus.start      = 1'b0;
      bus.data_key   = '0;
      bus.data_state = '0;

      // model pinned to the published vectors
      chk("model_ct1", encrypt('0, '0), CT1);
      chk("model_ct2", encrypt(ONES, ONES), CT2);
      chk("model_ct3", encrypt(CT1, CT2), CT3);

      repeat (2) @(negedge clk);
      chk("reset_busy", 128'(bus.busy), 128'h0);
      chk("reset_valid", 128'(bus.valid), 128'h0);
      chk("reset_data_out", bus.data_out, 128'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: zero key / zero plaintext, with latency
      start_run('0, '0);
      wait_valid("s1", CT1, lat);
      chk("s1_latency", 128'(lat), 128'd18);

      // 2: all-ones
      start_run(ONES, ONES);
      wait_valid("s2", CT2, lat);
      chk("s2_latency", 128'(lat), 128'd18);

      // 5a: start during round 5 with other data is ignored
      start_run(CT1, CT2);
      repeat (5) @(negedge clk);
      bus.data_key   = 128'h0123456789abcdef0123456789abcdef;
      bus.data_state = 128'hfedcba9876543210fedcba9876543210;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
      wait_valid("s5_ignored", CT3, lat);

      // 5b: back-to-back start in the valid cycle
      bus.data_key   = '0;
      bus.data_state = '0;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
      wait_valid("s5_b2b", CT1, lat);
      chk("s5_b2b_latency", 128'(lat), 128'd18);

      // 6: reset during round 8 clears outputs immediately
      start_run(ONES, ONES);
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("s6_rst_busy", 128'(bus.busy), 128'h0);
      chk("s6_rst_valid", 128'(bus.valid), 128'h0);
      chk("s6_rst_data_out", bus.data_out, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      start_run('0, '0);
      wait_valid("s6_restart", CT1, lat);
      chk("s6_restart_latency", 128'(lat), 128'd18);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
